// File: rtl/prio_demux_pkg.sv
// Shared channel indices, route state encoding and the enable-priority route decode.
package prio_demux_pkg;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } route_state_t;

    // en3 has top priority, matching the 4-to-1 priority select
    function automatic logic [1:0] route_decode(input logic en1, input logic en2, input logic en3);
        logic [1:0] ch;
        if (!en3)
            ch = CH_D;
        else if (!en2)
            ch = CH_C;
        else if (en1)
            ch = CH_B;
        else
            ch = CH_A;
        return ch;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single channel.
// Latency: load visible on out_* the cycle after; load and drain may coincide.
// Backpressure: holds its beat while out_ready is low; data/last hold when empty.
module demux_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/prio_demux_router.sv
// Registered 1-to-4 priority router; route chosen from en* at packet start and locked to in_last.
// Latency: 1 cycle accept-to-output, 1 beat/cycle per channel; optional dlv_cnt via PRIO_DEMUX_CNT_EN.
// Backpressure: in_ready follows only the routed slot; other channels drain independently.
module prio_demux_router
    import prio_demux_pkg::*;
#(
    parameter int DW = 8
`ifdef PRIO_DEMUX_CNT_EN
    ,
    parameter int CW = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en1,
    input  logic            en2,
    input  logic            en3,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            in_last,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*DW-1:0] out_data,
    output logic [3:0]      out_last
`ifdef PRIO_DEMUX_CNT_EN
    ,
    output logic [4*CW-1:0] dlv_cnt
`endif
);

    route_state_t state_q, state_d;
    logic [1:0]   route_q, route_d;
    logic [1:0]   live_route;
    logic [1:0]   route;
    logic         accept;
    logic [3:0]   load;

    assign live_route = route_decode(en1, en2, en3);
    assign route      = (state_q == BUSY) ? route_q : live_route;
    assign in_ready   = ~out_valid[route] | out_ready[route];
    assign accept     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            route_q <= CH_A;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        case (state_q)
            IDLE: begin
                if (accept && !in_last) begin
                    state_d = BUSY;
                    route_d = live_route;
                end
            end
            BUSY: begin
                if (accept && in_last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_ch
        assign load[k] = accept && (route == 2'(k));

        demux_slot #(.DW(DW)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .load_data (in_data),
            .load_last (in_last),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DW +: DW]),
            .out_last  (out_last[k])
        );

`ifdef PRIO_DEMUX_CNT_EN
        // counts drained packet ends, wrapping modulo 2^CW
        logic [CW-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (rst)
                cnt_q <= '0;
            else if (out_valid[k] && out_ready[k] && out_last[k])
                cnt_q <= cnt_q + CW'(1);
        end

        assign dlv_cnt[k*CW +: CW] = cnt_q;
`endif
    end

endmodule

// File: tb/tb_prio_demux_router.sv
// Self-checking bench for prio_demux_router: vector table, directed corner sequences, random run vs model.
module tb_prio_demux_router;

    localparam int DW    = 8;
    localparam int TB_CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            en1, en2, en3;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            in_last;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*DW-1:0] out_data;
    logic [3:0]      out_last;
`ifdef PRIO_DEMUX_CNT_EN
    logic [4*TB_CW-1:0] dlv_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prio_demux_router #(
        .DW (DW)
`ifdef PRIO_DEMUX_CNT_EN
        ,
        .CW (TB_CW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en1       (en1),
        .en2       (en2),
        .en3       (en3),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef PRIO_DEMUX_CNT_EN
        ,
        .dlv_cnt   (dlv_cnt)
`endif
    );

    // Reference model: what each channel holds, and whether a packet is in flight.
    logic          m_vld [4];
    logic [DW-1:0] m_dat [4];
    logic          m_lst [4];
    logic          m_in_pkt;
    int            m_pkt_ch;
    int            m_cnt [4];

    function automatic int pick_channel(input logic e1, input logic e2, input logic e3);
        if (!e3) return 3;
        if (!e2) return 2;
        if (e1)  return 1;
        return 0;
    endfunction

    function automatic int model_route();
        return m_in_pkt ? m_pkt_ch : pick_channel(en1, en2, en3);
    endfunction

    function automatic logic model_ready();
        int r = model_route();
        return !m_vld[r] || out_ready[r];
    endfunction

    task automatic model_step();
        int  r;
        logic acc;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_vld[k] = 1'b0;
                m_dat[k] = '0;
                m_lst[k] = 1'b0;
                m_cnt[k] = 0;
            end
            m_in_pkt = 1'b0;
            m_pkt_ch = 0;
            return;
        end
        r   = model_route();
        acc = in_valid && model_ready();
        for (int k = 0; k < 4; k++) begin
            if (m_vld[k] && out_ready[k] && m_lst[k])
                m_cnt[k] = (m_cnt[k] + 1) % (1 << TB_CW);
            if (acc && k == r) begin
                m_vld[k] = 1'b1;
                m_dat[k] = in_data;
                m_lst[k] = in_last;
            end else if (m_vld[k] && out_ready[k]) begin
                m_vld[k] = 1'b0;
            end
        end
        if (acc) begin
            m_in_pkt = !in_last;
            m_pkt_ch = r;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are already applied; check in_ready, clock once, check registered outputs.
    task automatic cycle();
        logic [3:0]      ev;
        logic [3:0]      el;
        logic [4*DW-1:0] ed;
        #2;
        chk("in_ready", {63'd0, in_ready}, {63'd0, model_ready()});
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            ev[k]            = m_vld[k];
            el[k]            = m_lst[k];
            ed[k*DW +: DW]   = m_dat[k];
        end
        chk("out_valid", {60'd0, out_valid}, {60'd0, ev});
        chk("out_last", {60'd0, out_last}, {60'd0, el});
        chk("out_data", {32'd0, out_data}, {32'd0, ed});
`ifdef PRIO_DEMUX_CNT_EN
        for (int k = 0; k < 4; k++)
            chk("dlv_cnt", {48'd0, dlv_cnt[k*TB_CW +: TB_CW]}, 64'(m_cnt[k]));
`endif
    endtask

    task automatic set_en(input logic [2:0] e);
        {en3, en2, en1} = e;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        cycle();
    endtask

    typedef struct {
        logic [2:0]    en;
        logic [DW-1:0] dat;
        int            ch;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{en: 3'b011, dat: 8'h11, ch: 3};
        vecs[1] = '{en: 3'b101, dat: 8'h22, ch: 2};
        vecs[2] = '{en: 3'b111, dat: 8'h33, ch: 1};
        vecs[3] = '{en: 3'b110, dat: 8'h44, ch: 0};

        for (int k = 0; k < 4; k++) begin
            m_vld[k] = 1'b0;
            m_dat[k] = '0;
            m_lst[k] = 1'b0;
            m_cnt[k] = 0;
        end
        m_in_pkt = 1'b0;
        m_pkt_ch = 0;

        rst       = 1'b1;
        set_en(3'b111);
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 4'b1111;
        cycle();
        cycle();
        chk("rst_out_valid", {60'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_last", {60'd0, out_last}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;

        // single-beat routing table
        for (int i = 0; i < 4; i++) begin
            set_en(vecs[i].en);
            beat(vecs[i].dat, 1'b1);
            chk("tbl_valid", {60'd0, out_valid}, 64'(1 << vecs[i].ch));
            chk("tbl_data", {56'd0, out_data[vecs[i].ch*DW +: DW]}, {56'd0, vecs[i].dat});
            chk("tbl_last", {63'd0, out_last[vecs[i].ch]}, 64'd1);
        end
        in_valid = 1'b0;
        cycle();

        // route lock: en3 rises after the first beat, packet stays on ch_d
        set_en(3'b011);
        for (int i = 0; i < 4; i++) begin
            beat(8'hA0 + 8'(i), i == 3);
            if (i == 0) set_en(3'b111);
            chk("lock_valid", {60'd0, out_valid}, 64'b1000);
            chk("lock_data", {56'd0, out_data[3*DW +: DW]}, 64'(8'hA0 + 8'(i)));
            chk("lock_last", {63'd0, out_last[3]}, 64'(i == 3));
        end
        in_valid = 1'b0;
        cycle();

        // backpressure on ch_b, ch_a beat waits for the ch_b packet to end
        out_ready = 4'b1101;
        set_en(3'b111);
        beat(8'hB0, 1'b0);
        chk("bp_first_held", {60'd0, out_valid}, 64'b0010);
        in_data = 8'hB1;
        in_last = 1'b1;
        #2;
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        cycle();
        set_en(3'b110);
        #2;
        chk("bp_locked_low", {63'd0, in_ready}, 64'd0);
        cycle();
        chk("bp_still_b0", {56'd0, out_data[1*DW +: DW]}, 64'hB0);
        out_ready = 4'b1111;
        cycle();
        chk("bp_b1_data", {56'd0, out_data[1*DW +: DW]}, 64'hB1);
        chk("bp_b1_last", {63'd0, out_last[1]}, 64'd1);
        beat(8'hC0, 1'b1);
        chk("bp_a_after", {60'd0, out_valid}, 64'b0001);
        chk("bp_a_data", {56'd0, out_data[0 +: DW]}, 64'hC0);
        in_valid = 1'b0;
        cycle();

        // ch_c drains and loads in the same cycle
        set_en(3'b101);
        beat(8'hD0, 1'b1);
        in_data = 8'hD1;
        #2;
        chk("da_in_ready", {63'd0, in_ready}, 64'd1);
        cycle();
        chk("da_valid", {60'd0, out_valid}, 64'b0100);
        chk("da_data", {56'd0, out_data[2*DW +: DW]}, 64'hD1);
        in_valid = 1'b0;
        cycle();

        // reset aborts a packet to ch_a
        set_en(3'b110);
        beat(8'hE0, 1'b0);
        beat(8'hE1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_valid", {60'd0, out_valid}, 64'd0);
        chk("mid_rst_last", {60'd0, out_last}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        set_en(3'b011);
        beat(8'hF0, 1'b1);
        chk("post_rst_route", {60'd0, out_valid}, 64'b1000);
        in_valid = 1'b0;
        cycle();

`ifdef PRIO_DEMUX_CNT_EN
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_en(3'b111);
        beat(8'h01, 1'b1);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b1);
        beat(8'h04, 1'b1);
        set_en(3'b000);
        beat(8'h05, 1'b1);
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("cnt_a", {48'd0, dlv_cnt[0*TB_CW +: TB_CW]}, 64'd0);
        chk("cnt_b", {48'd0, dlv_cnt[1*TB_CW +: TB_CW]}, 64'd3);
        chk("cnt_c", {48'd0, dlv_cnt[2*TB_CW +: TB_CW]}, 64'd0);
        chk("cnt_d", {48'd0, dlv_cnt[3*TB_CW +: TB_CW]}, 64'd1);
`endif

        // random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            set_en(3'($urandom));
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            in_last  = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < 4; k++)
                out_ready[k] = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/prio_demux_router.md
# prio_demux_router

Registered 1-to-4 priority demultiplexer/router: accepts a single valid/ready data stream and steers each packet to one of four output channels. The destination is chosen by the same three-level enable priority the team's 4-to-1 priority select uses (en3 highest, then en2, then en1). The block sits downstream of a shared source and fans it out to the a/b/c/d consumers. Each channel has a one-entry output register. The route is locked for the whole packet.

## Interface
Parameters:
- DW, 8, data width in bits.
- CW, 16, width of per-channel delivery counters (only with CNT feature).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- en1, en2, en3  in  1 each  route-select enables.
- in_valid  in  1  source beat valid.
- in_ready  out  1  block accepts beat this cycle.
- in_data  in  DW  source beat data.
- in_last  in  1  final beat of packet.
- out_valid  out  4  per-channel valid; bit 0 = ch_a, 1 = ch_b, 2 = ch_c, 3 = ch_d.
- out_ready  in  4  per-channel consumer ready.
- out_data  out  4*DW  per-channel data; channel k in bits [k*DW +: DW].
- out_last  out  4  per-channel last flag.
- dlv_cnt  out  4*CW  per-channel completed-packet count (present only with PRIO_DEMUX_CNT_EN).

## Operation
- Route decode (combinational from en*):
  - ~en3 gives ch_d (3).
  - Otherwise ~en2 gives ch_c (2).
  - Otherwise en1 gives ch_b (1).
  - Otherwise ch_a (0).
- Route FSM, states IDLE and BUSY:
  - IDLE: the route is the live decode. An accepted beat with in_last=0 latches the decoded route into route_q and moves to BUSY.
  - An accepted beat with in_last=1 stays in IDLE (single-beat packet).
  - BUSY: the route is route_q, and en* changes are ignored. An accepted beat with in_last=1 returns to IDLE.
- Channel slot k:
  - EMPTY→FULL on accept to k.
  - FULL→EMPTY on out_valid[k]&out_ready[k] with no accept to k that cycle.
  - Drain and accept in the same cycle keep the slot FULL with the new beat loaded.
- in_ready = ~out_valid[r] | out_ready[r], where r is the current route. in_ready does not depend on in_valid.
- Accept condition: in_valid & in_ready.
- Non-selected channels drain independently; a stall on one channel never blocks draining of the others.
- out_data and out_last of an EMPTY slot hold their last value. Consumers must qualify them with out_valid.

## Timing
- Latency is 1 cycle: a beat accepted at edge N shows on out_* after edge N.
- Full throughput is 1 beat/cycle into a channel whose consumer holds ready high.
- Reset values:
  - out_valid=0, out_data=0, out_last=0.
  - FSM in IDLE, route_q=0.
  - dlv_cnt=0.
  - in_ready evaluates to 1 after reset.
- A route change in IDLE takes effect on the same cycle's decode. There is no bubble between packets to different channels.
- Reset asserted mid-packet aborts the packet:
  - All slots go EMPTY and the FSM returns to IDLE.
  - The partial packet is lost; no out_last is generated.
- in_valid low in BUSY holds the state (gaps inside a packet are legal).

## Configuration
- PRIO_DEMUX_CNT_EN defined:
  - dlv_cnt is present.
  - Channel k increments when out_valid[k]&out_ready[k]&out_last[k]. This counts drained packet ends, not accepted ones.
  - The count wraps modulo 2^CW and saturation is not applied.
- Not defined:
  - The dlv_cnt port and counters are absent.
  - All other behaviour is identical.

## Structure
- Shared package prio_demux_pkg holds:
  - Channel index constants CH_A=0, CH_B=1, CH_C=2, CH_D=3.
  - The route state enum (IDLE, BUSY).
  - A route_decode function (en1, en2, en3 → 2-bit channel).
- Sub-module demux_slot: one-entry output register with valid/ready, load and drain. It is instantiated 4 times. The FSM, ready mux and counters live in the top level.

## Test plan
- Single beats, {en3,en2,en1} stepped through the sequence below, all out_ready=1. Each beat appears one cycle later on the indicated channel with out_last=1.
  - 0xx, data 0x11, goes to ch_d.
  - 10x, data 0x22, goes to ch_c.
  - 111, data 0x33, goes to ch_b.
  - 110, data 0x44, goes to ch_a.
- Route lock: 4-beat packet 0xA0..0xA3 started with en3=0, then en3 toggled to 1 after beat 0. All four beats reach ch_d and out_last is set only on 0xA3.
- Backpressure: ch_b out_ready=0 while 2 beats are sent to ch_b.
  - First beat sits in the slot and in_ready drops.
  - Raising out_ready then drains 1 beat per cycle.
  - Meanwhile a ch_a-routed beat stays blocked until the ch_b packet ends.
- Simultaneous drain and accept: ch_c FULL with out_ready=1 and a new beat offered. in_ready=1, the slot stays FULL with the new data, and there is no bubble.
- Reset mid-packet: rst pulsed after beat 1 of a 3-beat packet to ch_a.
  - Next cycle out_valid=0000 and in_ready=1.
  - A following packet routes by the live en* values.
- With PRIO_DEMUX_CNT_EN: 3 packets to ch_b and 1 to ch_d, all drained. Result dlv_cnt ch_b=3, ch_d=1, others 0.
  - With CW=2, 5 packets to ch_a give dlv_cnt ch_a=1 (wrap).
